// File: rtl/ifra_pkg.sv
// Shared definitions for the ifra req/ack write link: FSM state encoding and
// the default data width / buffer depth also used by the master BFM.
package ifra_pkg;

    localparam int IFRA_DATA_WIDTH = 8;
    localparam int IFRA_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IFRA_IDLE    = 2'd0,
        IFRA_ACK     = 2'd1,
        IFRA_RELEASE = 2'd2
    } ifra_state_t;

endpackage

// File: rtl/ifra_if.sv
// Bundle of the req/ack write link plus the downstream valid/ready stream.
// The master modport is the side that drives req/din and consumes the stream
// (m_ready); the slave modport is the responder.
interface ifra_if #(
    parameter int DATA_WIDTH = ifra_pkg::IFRA_DATA_WIDTH
);

    logic                  req;
    logic [DATA_WIDTH-1:0] din;
    logic                  ack;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output req,
        output din,
        output m_ready,
        input  ack,
        input  m_valid,
        input  m_data
    );

    modport slave (
        input  req,
        input  din,
        input  m_ready,
        output ack,
        output m_valid,
        output m_data
    );

endinterface

// File: rtl/ifra_fifo.sv
// Small fall-through FIFO: the head word is visible on rdata whenever the
// buffer is non-empty. Pushes when full and pops when empty are ignored.
// FIFO_DEPTH must be a power of two so the pointers wrap by overflow.
module ifra_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           level_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_FULL);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = level_reg;
    // Drive zero when empty so the output is clean out of reset.
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/ifra_slv.sv
// Responder for the ifra req/ack write link. Captures one word per req
// assertion, answers with a one-cycle ack, waits for req to drop, and
// buffers captured words toward a valid/ready stream. ack is withheld while
// the buffer is full, which back-pressures the master.
module ifra_slv
    import ifra_pkg::*;
#(
    parameter int DATA_WIDTH = IFRA_DATA_WIDTH,
    parameter int FIFO_DEPTH = IFRA_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    ifra_if.slave                       bus,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        ovf_err
);

    ifra_state_t state_reg;
    ifra_state_t state_next;
    logic        ack_reg;
    logic        ack_next;
    logic        ovf_reg;
    logic        ovf_next;
    logic        push;
    logic        full;
    logic        empty;

    ifra_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.m_ready),
        .wdata (bus.din),
        .rdata (bus.m_data),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    assign bus.m_valid = ~empty;
    assign bus.ack     = ack_reg;
    assign ovf_err     = ovf_reg;

    // State, ack and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IFRA_IDLE;
            ack_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state logic: capture in IDLE only if the registered level has room,
    // then insist that req stays up through the ack cycle and finally drops.
    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        ovf_next   = ovf_reg;
        push       = 1'b0;
        case (state_reg)
            IFRA_IDLE: begin
                if (bus.req && !full) begin
                    push       = 1'b1;
                    ack_next   = 1'b1;
                    state_next = IFRA_ACK;
                end
            end
            IFRA_ACK: begin
                if (bus.req) begin
                    state_next = IFRA_RELEASE;
                end else begin
                    // Master withdrew req before seeing ack.
                    ovf_next   = 1'b1;
                    state_next = IFRA_IDLE;
                end
            end
            IFRA_RELEASE: begin
                if (!bus.req) begin
                    state_next = IFRA_IDLE;
                end
            end
            default: begin
                state_next = IFRA_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifra_slv.sv
// Bench for ifra_slv: a BFM master issues directed writes and pushes the
// expected words into a scoreboard queue; a monitor pops and compares on
// every downstream transfer and tracks ack pulses.
module tb_ifra_slv;
    import ifra_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [$clog2(DEPTH):0]    level;
    logic                      ovf_err;

    ifra_if #(.DATA_WIDTH(DW)) bus ();

    ifra_slv #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .level   (level),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    int            total     = 0;
    int            bad       = 0;
    logic [DW-1:0] exp_q [$];
    int            ack_cnt   = 0;
    int            valid_cyc = 0;
    int            cyc       = 0;
    int            ack_t [$];
    logic          ack_prev  = 1'b0;
    int            a0;
    int            v0;
    int            t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: ack pulse tracking and scoreboard compare on each transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_prev = 1'b0;
            end else begin
                cyc++;
                if (bus.ack) begin
                    ack_cnt++;
                    ack_t.push_back(cyc);
                    check("ack_width", {31'b0, ack_prev}, 32'd0);
                end
                ack_prev = bus.ack;
                if (bus.m_valid) valid_cyc++;
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got=%0h want=none", bus.m_data);
                    end else begin
                        $display("pop  data=%02h", bus.m_data);
                        check("sb_data", {24'b0, bus.m_data}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = bus.ack;
        end
        check({name, "_ack"}, {31'b0, got}, 32'd1);
    endtask

    // BFM write: hold req until ack, keep it through `hold` more edges, then drop.
    task automatic bfm_write(input logic [DW-1:0] d, input int hold);
        exp_q.push_back(d);
        $display("write data=%02h", d);
        bus.din = d;
        bus.req = 1'b1;
        wait_ack("wr");
        repeat (hold) @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = 1'b0;
        bus.din     = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",    {31'b0, bus.ack},     32'd0);
        check("rst_valid",  {31'b0, bus.m_valid}, 32'd0);
        check("rst_level",  {29'b0, level},       32'd0);
        check("rst_ovf",    {31'b0, ovf_err},     32'd0);
        check("rst_mdata",  {24'b0, bus.m_data},  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write
        bus.m_ready = 1'b1;
        a0 = ack_cnt;
        v0 = valid_cyc;
        bfm_write(8'hA5, 1);
        repeat (3) @(posedge clk);
        #1;
        check("single_acks",  ack_cnt - a0,   32'd1);
        check("single_valid", valid_cyc - v0, 32'd1);
        check("single_level", {29'b0, level}, 32'd0);
        check("single_ovf",   {31'b0, ovf_err}, 32'd0);

        // Burst, ack spacing of 3 clocks
        a0 = ack_cnt;
        t0 = ack_t.size();
        for (int i = 1; i <= 4; i++) bfm_write(8'(i), 1);
        repeat (3) @(posedge clk);
        #1;
        check("burst_acks", ack_cnt - a0, 32'd4);
        for (int k = 1; k <= 3; k++)
            check("burst_gap", ack_t[t0 + k] - ack_t[t0 + k - 1], 32'd3);

        // Backpressure: 6 words into a 4-deep buffer with m_ready low
        bus.m_ready = 1'b0;
        a0 = ack_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) bfm_write(8'(16 + i), 1);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                check("bp_level", {29'b0, level},      32'd4);
                check("bp_acks",  ack_cnt - a0,        32'd4);
                check("bp_ack",   {31'b0, bus.ack},    32'd0);
                check("bp_head",  {24'b0, bus.m_data}, 32'h10);
                bus.m_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_drain_level", {29'b0, level}, 32'd0);
        check("bp_total_acks",  ack_cnt - a0,   32'd6);
        check("bp_queue",       exp_q.size(),   32'd0);

        // Full plus a one-cycle pop: no push on the pop edge, push on the next
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) bfm_write(8'(32 + i), 1);
        fork
            bfm_write(8'h24, 1);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("fp_level_full", {29'b0, level},   32'd4);
                check("fp_ack_full",   {31'b0, bus.ack}, 32'd0);
                bus.m_ready = 1'b1;
                @(posedge clk);
                #1 bus.m_ready = 1'b0;
                @(negedge clk);
                check("fp_level_pop", {29'b0, level},   32'd3);
                check("fp_ack_pop",   {31'b0, bus.ack}, 32'd0);
                @(negedge clk);
                check("fp_level_refill", {29'b0, level},   32'd4);
                check("fp_ack_refill",   {31'b0, bus.ack}, 32'd1);
            end
        join
        bus.m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("fp_drain_level", {29'b0, level}, 32'd0);

        // req held high long after ack: exactly one capture
        a0 = ack_cnt;
        exp_q.push_back(8'h77);
        $display("write data=77 (held)");
        bus.din = 8'h77;
        bus.req = 1'b1;
        wait_ack("held");
        repeat (10) @(posedge clk);
        #1;
        check("held_state", {30'b0, dut.state_reg}, {30'b0, IFRA_RELEASE});
        check("held_acks",  ack_cnt - a0,           32'd1);
        check("held_level", {29'b0, level},         32'd0);
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        check("held_idle", {30'b0, dut.state_reg}, {30'b0, IFRA_IDLE});
        bfm_write(8'h78, 1);
        check("held_next_acks", ack_cnt - a0, 32'd2);

        // Async reset mid-burst with level=2 in RELEASE
        bus.m_ready = 1'b0;
        bfm_write(8'h31, 1);
        exp_q.push_back(8'h32);
        $display("write data=32 (reset pending)");
        bus.din = 8'h32;
        bus.req = 1'b1;
        wait_ack("rm");
        @(posedge clk);
        #1;
        check("rm_state", {30'b0, dut.state_reg}, {30'b0, IFRA_RELEASE});
        check("rm_level", {29'b0, level},         32'd2);
        #2 rst = 1'b1;
        #1;
        check("rm_ack",   {31'b0, bus.ack},     32'd0);
        check("rm_valid", {31'b0, bus.m_valid}, 32'd0);
        check("rm_lvl0",  {29'b0, level},       32'd0);
        check("rm_mdata", {24'b0, bus.m_data},  32'd0);
        exp_q.delete();
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rm_post_state", {30'b0, dut.state_reg}, {30'b0, IFRA_IDLE});
        check("rm_post_level", {29'b0, level},         32'd0);
        check("rm_post_ack",   {31'b0, bus.ack},       32'd0);

        // Master withdraws req during ACK: sticky ovf_err
        bus.m_ready = 1'b1;
        exp_q.push_back(8'h5A);
        $display("write data=5a (early drop)");
        bus.din = 8'h5A;
        bus.req = 1'b1;
        wait_ack("ovf");
        bus.req = 1'b0;
        @(negedge clk);
        check("ovf_set",   {31'b0, ovf_err},       32'd1);
        check("ovf_state", {30'b0, dut.state_reg}, {30'b0, IFRA_IDLE});
        repeat (3) @(posedge clk);
        #1;
        bfm_write(8'h5B, 1);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_sticky", {31'b0, ovf_err}, 32'd1);
        check("ovf_level",  {29'b0, level},   32'd0);
        check("end_queue",  exp_q.size(),     32'd0);
        rst = 1'b1;
        #1;
        check("ovf_clear", {31'b0, ovf_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifra_slv.md
Name: ifra_slv

Overview:
Synthesizable responder (slave) for the req/ack write interface driven by the ifra master BFM. It captures `din` while `req` is high and returns a one-cycle `ack` pulse. It then waits for `req` to drop before accepting the next word. Captured words are buffered in a small FIFO and presented on a valid/ready stream toward downstream logic. `ack` is withheld while the FIFO is full, which gives backpressure to the master.

Parameters:
DATA_WIDTH, 8, width of din and m_data.
FIFO_DEPTH, 4, buffer entries; power of 2, >= 2.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
req  input  1  write request from master; level, held until ack seen.
din  input  DATA_WIDTH  write data; valid while req=1.
ack  output  1  registered one-cycle acknowledge pulse.
m_valid  output  1  FIFO non-empty.
m_data  output  DATA_WIDTH  FIFO head word (fall-through).
m_ready  input  1  downstream accepts head when m_valid=1.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
ovf_err  output  1  sticky; set if req is low while in ACK state (master withdrew early).

Behaviour:
- Reset (async assert, sync release) forces:
  - ack=0, m_valid=0, level=0, ovf_err=0.
  - state=IDLE; FIFO pointers cleared.
  - m_data is don't-care but is driven as 0.
- FSM states: IDLE, ACK, RELEASE.
  - IDLE: if req=1 and level<FIFO_DEPTH at posedge, then:
    - push din;
    - ack<=1;
    - go to ACK.
    Otherwise ack stays 0 and the FSM stays in IDLE. A stalled req is not an error.
  - ACK: ack<=0 unconditionally.
    - If req=1, go to RELEASE.
    - If req=0, set ovf_err and go to IDLE.
  - RELEASE: stay until req=0 is sampled, then go to IDLE. ack stays 0.
- Exactly one push per req assertion. Holding req high never causes a second capture.
- Latency:
  - req rising (sampled at edge N) gives ack high during cycle N..N+1.
  - The word is visible on m_valid/m_data after edge N (level increments at N).
  - With the BFM timing (req drops after edge N+1 and re-rises after N+2), sustained throughput is one word per 3 clocks.
- The full check uses the registered level only. A pop in the same cycle does not enable a push when the FIFO is full; the push happens on the following eligible edge.
- Pop: when m_valid=1 and m_ready=1 at posedge, the head advances. m_ready is ignored when empty.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
- Reset mid-transfer:
  - Buffered data is discarded.
  - If req is still high after reset release, it is treated as a new request and captured again. This is decided behaviour.
- ovf_err clears only on reset.

Decomposition:
- Package ifra_pkg holds:
  - the typedef enum for the FSM state (IFRA_IDLE, IFRA_ACK, IFRA_RELEASE);
  - a default-width localparam shared with the master BFM.
- One sub-module, ifra_fifo, parameterized by DATA_WIDTH and FIFO_DEPTH:
  - inputs: push, pop, wdata;
  - outputs: rdata, empty, full, level;
  - same clk and rst.
- ifra_slv contains only the FSM, the ack register and ovf_err.

Test Plan:
- Single write, m_ready=1: BFM writes 0xA5 -> ack high exactly 1 cycle; m_valid high for 1 cycle with m_data=0xA5; level returns to 0; ovf_err=0.
- Burst, m_ready=1: BFM writes 0x01,0x02,0x03,0x04 -> four ack pulses spaced 3 clocks apart; m_data sequence 01,02,03,04 in order; no duplicates.
- Backpressure, m_ready=0, DEPTH=4: BFM writes 6 words -> 4 acks, then ack held low with level=4. Raise m_ready -> remaining 2 words acked after slots free; downstream receives all 6 in order.
- Full plus concurrent pop: level=4 with req pending and m_ready pulsed 1 cycle -> no push on the pop edge; push on the next edge; level goes 4->3->4.
- req held high for 10 cycles after ack -> exactly one push; FSM in RELEASE until req=0; then next req is accepted.
- Async rst asserted mid-burst (level=2, state=RELEASE) -> outputs zeroed immediately; after release, req=0 keeps IDLE. Separately, force req low in ACK -> ovf_err=1 and sticky until rst.
